stats_pcie_tlp_mc: RTL and testbench

STATS_PCIE_TLP_MC -- requirements
Module: stats_pcie_tlp_mc

---
 rtl/stats_pcie_tlp_mc.sv | 181 ++++++++++++++++++
 tb/tb_stats_pcie_tlp_mc.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stats_pcie_tlp_mc.sv
// Multi-channel PCIe TLP statistics collector: per-channel TLP/header/payload/EP
// counts are accumulated locally and flushed as (id, increment) words on a stream port.
module stats_pcie_tlp_mc #(
  parameter int unsigned CH_COUNT          = 5,
  parameter int unsigned TLP_SEG_COUNT     = 1,
  parameter int unsigned TLP_SEG_HDR_WIDTH = 128,
  parameter int unsigned STAT_INC_WIDTH    = 24,
  parameter int unsigned STAT_ID_WIDTH     = 5,
  parameter int unsigned UPDATE_PERIOD     = 1024
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [CH_COUNT*TLP_SEG_COUNT*TLP_SEG_HDR_WIDTH-1:0]  tlp_hdr,
  input  logic [CH_COUNT*TLP_SEG_COUNT-1:0]                    tlp_valid,
  input  logic [CH_COUNT*TLP_SEG_COUNT-1:0]                    tlp_sop,
  input  logic [CH_COUNT*TLP_SEG_COUNT-1:0]                    tlp_eop,
  output logic [STAT_INC_WIDTH-1:0]                            m_axis_stat_tdata,
  output logic [STAT_ID_WIDTH-1:0]                             m_axis_stat_tid,
  output logic                                                 m_axis_stat_tvalid,
  input  logic                                                 m_axis_stat_tready,
  input  logic                                                 update
);

  localparam int unsigned NSEG  = CH_COUNT * TLP_SEG_COUNT;
  localparam int unsigned NID   = CH_COUNT * 4;
  localparam int unsigned INC_W = 13;
  localparam int unsigned SUM_W = ((STAT_INC_WIDTH > INC_W) ? STAT_INC_WIDTH : INC_W) + 1;
  localparam int unsigned TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD + 1) : 1;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((64'd1 << STAT_INC_WIDTH) - 64'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EMIT} state_e;

  function automatic logic [STAT_INC_WIDTH-1:0] sat_add(input logic [STAT_INC_WIDTH-1:0] a,
                                                        input logic [INC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SAT_MAX) s = SAT_MAX;
    return STAT_INC_WIDTH'(s);
  endfunction

  logic                      seg_start_c [NSEG];
  logic [2:0]                seg_hdr_c   [NSEG];
  logic [10:0]               seg_pay_c   [NSEG];
  logic                      seg_ep_c    [NSEG];
  logic                      unused_c;

  logic [INC_W-1:0]          inc_d [NID];
  logic [INC_W-1:0]          inc_q [NID];
  logic [STAT_INC_WIDTH-1:0] acc_d [NID];
  logic [STAT_INC_WIDTH-1:0] acc_q [NID];
  logic [STAT_INC_WIDTH-1:0] acc_cur;
  state_e                    state_d, state_q;
  logic [STAT_ID_WIDTH-1:0]  idx_d, idx_q;
  logic [STAT_ID_WIDTH-1:0]  tid_d, tid_q;
  logic [STAT_INC_WIDTH-1:0] tdata_d, tdata_q;
  logic                      tvalid_d, tvalid_q;
  logic                      pend_d, pend_q;
  logic [TMR_W-1:0]          tmr_d, tmr_q;
  logic                      msb_any, trig, last_id;

  // Header fields only matter for segments that start a TLP; everything else is ignored.
  assign unused_c = ^{tlp_hdr, tlp_eop};

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    localparam int unsigned B = g * TLP_SEG_HDR_WIDTH;
    assign seg_start_c[g] = tlp_valid[g] & tlp_sop[g];
    assign seg_hdr_c[g]   = tlp_hdr[B+125] ? 3'd4 : 3'd3;
    assign seg_pay_c[g]   = !tlp_hdr[B+126]                ? 11'd0 :
                            (tlp_hdr[B+96 +: 10] == 10'd0) ? 11'd1024 :
                                                             {1'b0, tlp_hdr[B+96 +: 10]};
    assign seg_ep_c[g]    = tlp_hdr[B+110];
  end

  // Per-channel increment: all starting segments of a channel summed in one cycle.
  always_comb begin
    for (int i = 0; i < NID; i++) inc_d[i] = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      for (int s = 0; s < TLP_SEG_COUNT; s++) begin
        if (seg_start_c[c*TLP_SEG_COUNT+s]) begin
          inc_d[4*c]   = inc_d[4*c]   + INC_W'(1);
          inc_d[4*c+1] = inc_d[4*c+1] + INC_W'(seg_hdr_c[c*TLP_SEG_COUNT+s]);
          inc_d[4*c+2] = inc_d[4*c+2] + INC_W'(seg_pay_c[c*TLP_SEG_COUNT+s]);
          inc_d[4*c+3] = inc_d[4*c+3] + INC_W'(seg_ep_c[c*TLP_SEG_COUNT+s]);
        end
      end
    end
  end

  // Accumulate, scan and emit; a latched counter restarts from the increment landing that cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tid_d    = tid_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    pend_d   = pend_q;
    tmr_d    = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
    acc_cur  = '0;
    msb_any  = 1'b0;
    for (int i = 0; i < NID; i++) begin
      acc_d[i] = sat_add(acc_q[i], inc_q[i]);
      msb_any  = msb_any | acc_q[i][STAT_INC_WIDTH-1];
      if (idx_q == STAT_ID_WIDTH'(i)) acc_cur = acc_q[i];
    end
    trig    = update | msb_any | ((UPDATE_PERIOD != 0) && (tmr_q == '0));
    last_id = (idx_q == STAT_ID_WIDTH'(NID - 1));

    case (state_q)
      ST_IDLE: begin
        if (trig || pend_q) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          pend_d  = 1'b0;
          tmr_d   = TMR_W'(UPDATE_PERIOD);
        end
      end
      ST_SCAN: begin
        if (trig) pend_d = 1'b1;
        if (acc_cur != '0) begin
          tdata_d  = acc_cur;
          tid_d    = idx_q;
          tvalid_d = 1'b1;
          state_d  = ST_EMIT;
          for (int i = 0; i < NID; i++) begin
            if (idx_q == STAT_ID_WIDTH'(i)) acc_d[i] = sat_add(STAT_INC_WIDTH'(0), inc_q[i]);
          end
        end else if (last_id) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + STAT_ID_WIDTH'(1);
        end
      end
      ST_EMIT: begin
        if (trig) pend_d = 1'b1;
        if (m_axis_stat_tready) begin
          tvalid_d = 1'b0;
          if (last_id) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SCAN;
            idx_d   = idx_q + STAT_ID_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      tid_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      pend_q   <= 1'b0;
      tmr_q    <= TMR_W'(UPDATE_PERIOD);
      for (int i = 0; i < NID; i++) begin
        inc_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tid_q    <= tid_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      pend_q   <= pend_d;
      tmr_q    <= tmr_d;
      for (int i = 0; i < NID; i++) begin
        inc_q[i] <= inc_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign m_axis_stat_tdata  = tdata_q;
  assign m_axis_stat_tid    = tid_q;
  assign m_axis_stat_tvalid = tvalid_q;

endmodule

// File: tb/tb_stats_pcie_tlp_mc.sv
// Bench for stats_pcie_tlp_mc: a wide instance under directed and random traffic with a
// totals model, plus a narrow 8-bit instance for the MSB-triggered flush.
module tb_stats_pcie_tlp_mc;
  localparam int unsigned CH   = 5;
  localparam int unsigned SEG  = 2;
  localparam int unsigned HW   = 128;
  localparam int unsigned W    = 24;
  localparam int unsigned IDW  = 5;
  localparam int unsigned UP   = 512;
  localparam int unsigned NSEG = CH * SEG;
  localparam int unsigned NID  = CH * 4;
  localparam int unsigned SW   = 8;
  localparam int unsigned SIDW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSEG*HW-1:0]   tlp_hdr;
  logic [NSEG-1:0]      tlp_valid, tlp_sop, tlp_eop;
  logic [W-1:0]         tdata;
  logic [IDW-1:0]       tid;
  logic                 tvalid, tready, update;

  logic [HW-1:0]        s_hdr;
  logic [0:0]           s_valid, s_sop, s_eop;
  logic [SW-1:0]        s_tdata;
  logic [SIDW-1:0]      s_tid;
  logic                 s_tvalid, s_tready, s_update;

  longint in_tot [NID];
  longint out_tot[NID];
  longint s_in [4];
  longint s_out[4];
  int     s_words;
  int     wid_q[$];
  longint wdat_q[$];
  int     exp_id [3];
  longint exp_dat[3];
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  stats_pcie_tlp_mc #(
    .CH_COUNT(CH), .TLP_SEG_COUNT(SEG), .TLP_SEG_HDR_WIDTH(HW),
    .STAT_INC_WIDTH(W), .STAT_ID_WIDTH(IDW), .UPDATE_PERIOD(UP)
  ) u_dut (
    .clk(clk), .rst(rst), .tlp_hdr(tlp_hdr), .tlp_valid(tlp_valid), .tlp_sop(tlp_sop),
    .tlp_eop(tlp_eop), .m_axis_stat_tdata(tdata), .m_axis_stat_tid(tid),
    .m_axis_stat_tvalid(tvalid), .m_axis_stat_tready(tready), .update(update)
  );

  stats_pcie_tlp_mc #(
    .CH_COUNT(1), .TLP_SEG_COUNT(1), .TLP_SEG_HDR_WIDTH(HW),
    .STAT_INC_WIDTH(SW), .STAT_ID_WIDTH(SIDW), .UPDATE_PERIOD(0)
  ) u_small (
    .clk(clk), .rst(rst), .tlp_hdr(s_hdr), .tlp_valid(s_valid), .tlp_sop(s_sop),
    .tlp_eop(s_eop), .m_axis_stat_tdata(s_tdata), .m_axis_stat_tid(s_tid),
    .m_axis_stat_tvalid(s_tvalid), .m_axis_stat_tready(s_tready), .update(s_update)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input longint act, input longint bound);
    checks++;
    if (act < 1 || act > bound) begin
      errors++;
      $display("FAIL %s actual=%0d required=1..%0d", name, act, bound);
    end
  endtask

  function automatic longint hdr_dw(input logic [2:0] fmt);
    return fmt[0] ? 64'd4 : 64'd3;
  endfunction

  function automatic longint pay_dw(input logic [2:0] fmt, input logic [9:0] len);
    if (!fmt[1]) return 64'd0;
    return (len == 10'd0) ? 64'd1024 : longint'(len);
  endfunction

  task automatic clear_in();
    tlp_hdr   = '0;
    tlp_valid = '0;
    tlp_sop   = '0;
    tlp_eop   = '0;
    update    = 1'b0;
    s_hdr     = '0;
    s_valid   = '0;
    s_sop     = '0;
    s_eop     = '0;
    s_update  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic set_seg(input int c, input int sg, input logic [2:0] fmt, input logic [9:0] len,
                         input logic ep, input logic v, input logic sp);
    int            idx;
    logic [HW-1:0] h;
    idx = c * int'(SEG) + sg;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[127:125] = fmt;
    h[110]     = ep;
    h[105:96]  = len;
    tlp_hdr[idx*HW +: HW] = h;
    tlp_valid[idx] = v;
    tlp_sop[idx]   = sp;
    tlp_eop[idx]   = 1'($urandom);
    if (v && sp) begin
      in_tot[4*c]   += 1;
      in_tot[4*c+1] += hdr_dw(fmt);
      in_tot[4*c+2] += pay_dw(fmt, len);
      in_tot[4*c+3] += longint'(ep);
    end
  endtask

  task automatic s_set(input logic [2:0] fmt, input logic [9:0] len, input logic ep);
    logic [HW-1:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[127:125] = fmt;
    h[110]     = ep;
    h[105:96]  = len;
    s_hdr   = h;
    s_valid = 1'b1;
    s_sop   = 1'b1;
    s_in[0] += 1;
    s_in[1] += hdr_dw(fmt);
    s_in[2] += pay_dw(fmt, len);
    s_in[3] += longint'(ep);
  endtask

  function automatic longint qsum(input int id);
    longint s = 0;
    foreach (wid_q[k]) if (wid_q[k] == id) s += wdat_q[k];
    return s;
  endfunction

  task automatic expect3(input string tag);
    check({tag, "_nwords"}, longint'(wid_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_id%0d", tag, i), (i < wid_q.size()) ? longint'(wid_q[i]) : -1,
            longint'(exp_id[i]));
      check($sformatf("%s_data%0d", tag, i), (i < wdat_q.size()) ? wdat_q[i] : -1, exp_dat[i]);
    end
  endtask

  task automatic drain();
    next_cycle();
    tready = 1'b1;
    repeat (4) next_cycle();
    update = 1'b1;
    repeat (80) next_cycle();
    update = 1'b1;
    repeat (80) next_cycle();
  endtask

  task automatic check_totals(input string tag);
    for (int i = 0; i < NID; i++)
      check($sformatf("%s_total_id%0d", tag, i), out_tot[i], in_tot[i]);
  endtask

  // Every cycle: reset values, stall stability, and each word bounded by the un-flushed model count.
  task automatic monitor();
    bit             stall = 1'b0;
    logic [W-1:0]   pd = '0;
    logic [IDW-1:0] pi = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_tvalid", longint'(tvalid), 0);
        check("rst_tdata", longint'(tdata), 0);
        check("rst_tid", longint'(tid), 0);
        for (int i = 0; i < NID; i++) out_tot[i] = 0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_tvalid", longint'(tvalid), 1);
          check("hold_tdata", longint'(tdata), longint'(pd));
          check("hold_tid", longint'(tid), longint'(pi));
        end
        if (tvalid) begin
          if (int'(tid) < int'(NID)) begin
            check_le($sformatf("word_bound_id%0d", tid), longint'(tdata),
                     in_tot[tid] - out_tot[tid]);
            if (tready) begin
              out_tot[tid] += longint'(tdata);
              wid_q.push_back(int'(tid));
              wdat_q.push_back(longint'(tdata));
            end
          end else begin
            check("tid_range", longint'(tid), longint'(NID - 1));
          end
        end
        stall = tvalid && !tready;
        pd = tdata;
        pi = tid;
      end
    end
  endtask

  task automatic s_monitor();
    forever begin
      @(negedge clk);
      if (!rst && s_tvalid && s_tready) begin
        check_le("s_no_saturation", longint'(s_tdata), 254);
        s_out[s_tid] += longint'(s_tdata);
        s_words++;
      end
    end
  endtask

  initial begin
    bit found;
    int s_early;
    rst      = 1'b1;
    tready   = 1'b1;
    s_tready = 1'b1;
    s_words  = 0;
    clear_in();
    fork
      monitor();
      s_monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", longint'(tvalid), 0);
    check("reset_tdata", longint'(tdata), 0);
    check("reset_tid", longint'(tid), 0);
    rst = 1'b0;

    // Single MWr on channel 0
    wid_q.delete(); wdat_q.delete();
    next_cycle();
    set_seg(0, 0, 3'b011, 10'd16, 1'b0, 1'b1, 1'b1);
    next_cycle();
    update = 1'b1;
    repeat (60) next_cycle();
    exp_id = '{0, 1, 2}; exp_dat = '{1, 4, 16};
    expect3("mwr");

    // MRd with len=0 and EP on channel 2 seg 1, plus non-start distractors
    wid_q.delete(); wdat_q.delete();
    next_cycle();
    set_seg(2, 1, 3'b000, 10'd0, 1'b1, 1'b1, 1'b1);
    set_seg(2, 0, 3'b011, 10'd7, 1'b1, 1'b1, 1'b0);
    set_seg(3, 0, 3'b011, 10'd5, 1'b0, 1'b0, 1'b1);
    next_cycle();
    update = 1'b1;
    repeat (60) next_cycle();
    exp_id = '{8, 9, 11}; exp_dat = '{1, 3, 1};
    expect3("mrd");

    // Two starts per cycle for 10 cycles
    wid_q.delete(); wdat_q.delete();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      set_seg(0, 0, 3'b010, 10'd1, 1'b0, 1'b1, 1'b1);
      set_seg(0, 1, 3'b010, 10'd1, 1'b0, 1'b1, 1'b1);
    end
    next_cycle();
    update = 1'b1;
    repeat (60) next_cycle();
    check("seg2_id0", qsum(0), 20);
    check("seg2_id1", qsum(1), 60);
    check("seg2_id2", qsum(2), 20);
    check("seg2_id3", qsum(3), 0);
    check("model_id1", in_tot[1], 64);

    // Back-pressure for 50 cycles while channel 1 keeps counting
    tready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      set_seg(1, 0, 3'b001, 10'd5, 1'b1, 1'b1, 1'b1);
      if (i == 0) update = 1'b1;
      if (tvalid) begin
        found = 1'b1;
        break;
      end
    end
    check("stall_word_seen", longint'(found), 1);
    repeat (50) begin
      next_cycle();
      set_seg(1, 0, 3'b001, 10'd5, 1'b1, 1'b1, 1'b1);
    end
    drain();
    check_totals("stall");

    // Random traffic, back-pressure and update pulses
    for (int n = 0; n < 1500; n++) begin
      next_cycle();
      tready = ($urandom_range(0, 3) != 0);
      update = ($urandom_range(0, 24) == 0);
      for (int c = 0; c < CH; c++)
        for (int sg = 0; sg < SEG; sg++)
          set_seg(c, sg, 3'($urandom), 10'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    drain();
    check_totals("random");

    // Reset while a word is held
    tready = 1'b0;
    next_cycle();
    set_seg(4, 0, 3'b011, 10'd3, 1'b0, 1'b1, 1'b1);
    next_cycle();
    update = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      if (tvalid) begin
        found = 1'b1;
        break;
      end
    end
    check("pre_reset_word_seen", longint'(found), 1);
    rst = 1'b1;
    for (int i = 0; i < NID; i++) in_tot[i] = 0;
    #1;
    check("async_rst_tvalid", longint'(tvalid), 0);
    check("async_rst_tdata", longint'(tdata), 0);
    check("async_rst_tid", longint'(tid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tready = 1'b1;
    wid_q.delete(); wdat_q.delete();
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      if (i % 20 == 0) update = 1'b1;
    end
    check("post_reset_words", longint'(wid_q.size()), 0);
    next_cycle();
    set_seg(4, 1, 3'b000, 10'd2, 1'b1, 1'b1, 1'b1);
    drain();
    check_totals("post_reset");
    check("post_reset_id17", out_tot[17], 3);

    // 8-bit instance: 200 starts, no update, flush must come from the MSB request
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      if (i % 2 == 0) s_set(3'b011, 10'd1, 1'b0);
    end
    s_early = s_words;
    check_le("small_msb_flush_words", longint'(s_early), 1000);
    repeat (4) next_cycle();
    s_update = 1'b1;
    repeat (40) next_cycle();
    s_update = 1'b1;
    repeat (40) next_cycle();
    check("small_model_id1", s_in[1], 800);
    for (int i = 0; i < 4; i++)
      check($sformatf("small_total_id%0d", i), s_out[i], s_in[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
